// File: rtl/steer_en_ctrl.sv
// Rider-presence / steering-enable controller: registered load cells, weight
// hysteresis, balance settle timer. Define STEER_DBNC_EN for step-off debounce.
module steer_en_ctrl #(
    parameter int              LD_W         = 12,
    parameter logic [LD_W-1:0] MIN_RIDER_WT = 12'h200,
    parameter logic [LD_W-1:0] WT_HYST      = 12'h040,
    parameter int              TMR_W        = 26,
    parameter int              SETTLE_CNT   = 65_000_000,
    parameter int              DBNC_CYC     = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [LD_W-1:0] lft_ld,
    input  logic [LD_W-1:0] rght_ld,
    output logic            en_steer,
    output logic            rider_off,
    output logic [1:0]      steer_st,
    output logic            tmr_full
);

    localparam int PW = LD_W + 5;
    localparam logic [LD_W:0]      WT_ON    = (LD_W+1)'(MIN_RIDER_WT);
    localparam logic [LD_W:0]      WT_OFF   = (LD_W+1)'(MIN_RIDER_WT - WT_HYST);
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(SETTLE_CNT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, STEER_EN = 2'd2} st_t;

    st_t              state;
    logic [LD_W-1:0]  lft_q, rght_q;
    logic [LD_W:0]    sum;
    logic [LD_W-1:0]  diff;
    logic [PW-1:0]    sum_x, diff_x;
    logic [TMR_W-1:0] tmr;
    logic             sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16;
    logic             lt_exit;

    assign sum   = {1'b0, lft_q} + {1'b0, rght_q};
    assign diff  = (lft_q >= rght_q) ? (lft_q - rght_q) : (rght_q - lft_q);
    assign sum_x  = PW'(sum);
    assign diff_x = PW'(diff);

    assign sum_gt_min    = sum > WT_ON;
    assign sum_lt_min    = sum < WT_OFF;
    assign diff_gt_1_4   = (diff_x << 2) > sum_x;
    assign diff_gt_15_16 = (diff_x << 4) > ((sum_x << 4) - sum_x);

    assign tmr_full = (tmr == TMR_LAST);
    assign en_steer = (state == STEER_EN);
    assign steer_st = state;

`ifdef STEER_DBNC_EN
    localparam int DW = $clog2(DBNC_CYC + 1);
    logic [DW-1:0] dbnc_cnt;
    logic          st_move;

    assign lt_exit = sum_lt_min && (dbnc_cnt == DW'(DBNC_CYC - 1));
    // Any state change restarts the consecutive-light count.
    assign st_move = lt_exit
                   || (state == WAIT && !diff_gt_1_4 && tmr_full)
                   || (state == STEER_EN && diff_gt_15_16);

    always_ff @(posedge clk) begin
        if (rst)
            dbnc_cnt <= '0;
        else if (state == IDLE || !sum_lt_min || st_move)
            dbnc_cnt <= '0;
        else
            dbnc_cnt <= dbnc_cnt + 1'b1;
    end
`else
    assign lt_exit = sum_lt_min;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tmr       <= '0;
            lft_q     <= '0;
            rght_q    <= '0;
            rider_off <= 1'b0;
        end else begin
            lft_q     <= lft_ld;
            rght_q    <= rght_ld;
            rider_off <= 1'b0;
            case (state)
                IDLE: begin
                    tmr <= '0;
                    if (sum_gt_min) state <= WAIT;
                end
                WAIT: begin
                    if (lt_exit) begin
                        state     <= IDLE;
                        rider_off <= 1'b1;
                        tmr       <= '0;
                    end else if (diff_gt_1_4) begin
                        tmr <= '0;
                    end else if (tmr_full) begin
                        state <= STEER_EN;
                        tmr   <= '0;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                STEER_EN: begin
                    tmr <= '0;
                    if (lt_exit) begin
                        state     <= IDLE;
                        rider_off <= 1'b1;
                    end else if (diff_gt_15_16) begin
                        state <= WAIT;
                    end
                end
                default: begin
                    state <= IDLE;
                    tmr   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_steer_en_ctrl.sv
// Randomized load-cell stimulus against a cycle-level behavioural model of the
// rider/steer controller (SETTLE_CNT=16, DBNC_CYC=8).
module tb_steer_en_ctrl;

    localparam int SETTLE = 16;
    localparam int DBNC   = 8;
    localparam int WT_ON  = 'h200;
    localparam int WT_OFF = 'h200 - 'h040;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] lft_ld, rght_ld;
    logic        en_steer, rider_off, tmr_full;
    logic [1:0]  steer_st;

    steer_en_ctrl #(
        .LD_W(12), .MIN_RIDER_WT(12'h200), .WT_HYST(12'h040),
        .TMR_W(26), .SETTLE_CNT(SETTLE), .DBNC_CYC(DBNC)
    ) dut (
        .clk(clk), .rst(rst), .lft_ld(lft_ld), .rght_ld(rght_ld),
        .en_steer(en_steer), .rider_off(rider_off),
        .steer_st(steer_st), .tmr_full(tmr_full)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // reference state: 0 idle, 1 settling, 2 steering
    int m_st = 0, m_t = 0, m_d = 0, m_lq = 0, m_rq = 0;
    bit m_off = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input bit r, input int l, input int rr);
        int  s, df, prev;
        bit  gt, lt, q, h, ex;
        if (r) begin
            m_st = 0; m_t = 0; m_d = 0; m_lq = 0; m_rq = 0; m_off = 0;
            return;
        end
        s  = m_lq + m_rq;
        df = (m_lq > m_rq) ? m_lq - m_rq : m_rq - m_lq;
        gt = s > WT_ON;
        lt = s < WT_OFF;
        q  = 4 * df > s;
        h  = 16 * df > 15 * s;
`ifdef STEER_DBNC_EN
        ex = lt && (m_d == DBNC - 1);
`else
        ex = lt;
`endif
        prev  = m_st;
        m_off = 0;
        case (m_st)
            0: if (gt) begin m_st = 1; m_t = 0; end
            1: begin
                if (ex) begin m_st = 0; m_off = 1; m_t = 0; end
                else if (q) m_t = 0;
                else if (m_t == SETTLE - 1) begin m_st = 2; m_t = 0; end
                else m_t++;
            end
            default: begin
                if (ex) begin m_st = 0; m_off = 1; end
                else if (h) begin m_st = 1; m_t = 0; end
            end
        endcase
        m_d = (lt && prev != 0 && m_st == prev) ? m_d + 1 : 0;
        m_lq = l;
        m_rq = rr;
    endtask

    task automatic step(input bit r, input logic [11:0] l, input logic [11:0] rr);
        rst = r; lft_ld = l; rght_ld = rr;
        @(posedge clk);
        model(r, int'(l), int'(rr));
        #1;
        chk("steer_st",  int'(steer_st),  m_st);
        chk("en_steer",  int'(en_steer),  int'(m_st == 2));
        chk("rider_off", int'(rider_off), int'(m_off));
        chk("tmr_full",  int'(tmr_full),  int'(m_st == 1 && m_t == SETTLE - 1));
    endtask

    task automatic gen(input int mode, output logic [11:0] l, output logic [11:0] rr);
        int b;
        case (mode)
            0: begin
                b  = int'($urandom_range('h400, 'h110));
                l  = 12'(b);
                rr = 12'(b - int'($urandom_range(b / 8, 0)));
            end
            1: begin
                l  = 12'($urandom_range('h300, 'h200));
                rr = 12'($urandom_range('h90, 'h40));
            end
            2: begin l = 12'h3F0; rr = 12'($urandom_range(8, 0)); end
            3: begin l = 12'($urandom_range('hFF, 'hE1)); rr = l; end
            4: begin
                l  = 12'($urandom_range('h90, 0));
                rr = 12'($urandom_range('h90, 0));
            end
            5: begin l = 12'($urandom); rr = 12'($urandom); end
            default: begin
                if ($urandom_range(1, 0) == 1) gen(4, l, rr);
                else gen(0, l, rr);
            end
        endcase
    endtask

    task automatic hold(input logic [11:0] l, input logic [11:0] rr, input int n);
        for (int i = 0; i < n; i++) step(1'b0, l, rr);
    endtask

    initial begin
        logic [11:0] l, rr;
        int mode, len;
        rst = 1'b1; lft_ld = '0; rght_ld = '0;
        step(1'b1, 12'h0, 12'h0);
        step(1'b1, 12'h0, 12'h0);
        // settle, steer, hard imbalance, retry, hysteresis band, step off
        hold(12'h180, 12'h180, 20);
        hold(12'h3F0, 12'h008, 2);
        hold(12'h180, 12'h180, 12);
        hold(12'h200, 12'h080, 3);
        hold(12'h180, 12'h180, 20);
        hold(12'h0E8, 12'h0E8, 5);
        hold(12'h080, 12'h080, 10);
        hold(12'h180, 12'h180, 22);
        step(1'b1, 12'h180, 12'h180);
        hold(12'h180, 12'h180, 4);
        // debounce edges: 7 light cycles then 8
        hold(12'h180, 12'h180, 20);
        hold(12'h080, 12'h080, 7);
        hold(12'h180, 12'h180, 3);
        hold(12'h080, 12'h080, 8);
        hold(12'h080, 12'h080, 3);
        for (int seg = 0; seg < 150; seg++) begin
            if ($urandom_range(19, 0) == 0) begin
                step(1'b1, 12'(gen_dummy()), 12'h0);
                continue;
            end
            mode = int'($urandom_range(6, 0));
            len  = int'($urandom_range(40, 1));
            for (int i = 0; i < len; i++) begin
                gen(mode, l, rr);
                step(1'b0, l, rr);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    function automatic int gen_dummy();
        return int'($urandom_range('hFFF, 0));
    endfunction

endmodule
